// File: rtl/norm2_host.sv
// Host-side loader/driver for the norm2 sum-of-squares kernel: streams samples
// into the kernel array, fires it, and returns the 64-bit result over valid/ready.
module norm2_host #(
    parameter int DEPTH = 1000,
    parameter int AW    = 10,
    parameter int DW    = 27,
    parameter int RW    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic          controlArr,
    output logic          controlArrWEnable_a,
    output logic [AW-1:0] controlArrAddr_a,
    output logic [DW-1:0] controlArrWData_a,
    output logic          r_enable,
    output logic [63:0]   init_i,
    output logic [63:0]   init_acc,
    input  logic          w_enable,
    input  logic [RW-1:0] result
);

    typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, DONE} state_t;

    localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);
    localparam logic [AW-1:0] ONE     = AW'(1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] addr_cnt;

    assign init_i   = '0;
    assign init_acc = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            addr_cnt            <= '0;
            s_ready             <= 1'b0;
            busy                <= 1'b0;
            res_valid           <= 1'b0;
            res_data            <= '0;
            controlArr          <= 1'b1;
            controlArrWEnable_a <= 1'b0;
            controlArrAddr_a    <= '0;
            controlArrWData_a   <= '0;
            r_enable            <= 1'b0;
        end else begin
            controlArrWEnable_a <= 1'b0;
            r_enable            <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        addr_cnt <= '0;
                        cnt      <= (n > DEPTH_C) ? DEPTH_C : n;
                        if (n == '0) begin
                            state      <= FIRE;
                            r_enable   <= 1'b1;
                            controlArr <= 1'b0;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // s_ready low inside LOAD marks the cycle the final write is on the bus
                    if (!s_ready) begin
                        state      <= FIRE;
                        r_enable   <= 1'b1;
                        controlArr <= 1'b0;
                    end else if (s_valid) begin
                        controlArrWEnable_a <= 1'b1;
                        controlArrAddr_a    <= addr_cnt;
                        controlArrWData_a   <= s_data;
                        addr_cnt            <= addr_cnt + ONE;
                        if (addr_cnt == cnt - ONE)
                            s_ready <= 1'b0;
                    end
                end
                FIRE: state <= WAIT;
                WAIT: begin
                    if (w_enable) begin
                        res_data  <= result;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        busy       <= 1'b0;
                        controlArr <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_norm2_host.sv
// Directed bench for norm2_host with a behavioural sum-of-squares kernel model.
module tb_norm2_host;
    localparam int DEPTH = 1000;
    localparam int AW    = 10;
    localparam int DW    = 27;
    localparam int RW    = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] n = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          busy;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic          controlArr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          r_enable;
    logic [63:0]   init_i;
    logic [63:0]   init_acc;
    logic          w_enable;
    logic [RW-1:0] result;

    logic          kern_wen = 1'b0;
    logic          stray_wen = 1'b0;
    logic [63:0]   kern_res = '0;
    logic [63:0]   stray_res = '0;
    assign w_enable = kern_wen | stray_wen;
    assign result   = stray_wen ? stray_res : kern_res;

    norm2_host #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .controlArr(controlArr), .controlArrWEnable_a(we),
        .controlArrAddr_a(waddr), .controlArrWData_a(wdata),
        .r_enable(r_enable), .init_i(init_i), .init_acc(init_acc),
        .w_enable(w_enable), .result(result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor and kernel model state
    int      cyc = 0;
    int      wr_cnt = 0;
    int      wr_addr[4096];
    int      wr_cyc[4096];
    longint  mem[1024];
    int      r_en_cnt = 0;
    int      r_en_cyc = 0;
    int      wen_cyc = 0;
    logic    ctrl_at_fire = 1'b1;
    logic    we_at_fire = 1'b1;
    int      kern_n = 0;
    int      kern_delay = 3;
    int      kern_cd = 0;
    int      start_cyc = 0;
    int      rv_cyc = 0;

    logic signed [DW-1:0] sbuf[1024];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        longint acc;
        @(negedge clk);
        kern_wen = 1'b0;
        if (kern_cd > 0) begin
            kern_cd--;
            if (kern_cd == 0) begin
                kern_wen = 1'b1;
                wen_cyc  = cyc;
            end
        end
        if (rst_n) begin
            if (we) begin
                if (wr_cnt < 4096) begin
                    wr_addr[wr_cnt] = int'(waddr);
                    wr_cyc[wr_cnt]  = cyc;
                end
                wr_cnt++;
                mem[waddr] = longint'($signed(wdata));
            end
            if (r_enable) begin
                r_en_cnt++;
                r_en_cyc     = cyc;
                ctrl_at_fire = controlArr;
                we_at_fire   = we;
                acc = 0;
                for (int i = 0; i < kern_n; i++) acc += mem[i] * mem[i];
                kern_res = acc;
                kern_cd  = kern_delay + 1;
            end
        end
    end

    function automatic longint ref_sum(input int k);
        longint s = 0;
        for (int i = 0; i < k; i++) s += longint'(sbuf[i]) * longint'(sbuf[i]);
        return s;
    endfunction

    task automatic do_start(input int nv);
        start     = 1'b1;
        n         = AW'(nv);
        start_cyc = cyc;
        kern_n    = (nv > DEPTH) ? DEPTH : nv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int cnt, input bit bubbles, input int max_cyc, output int acc_n);
        int idx = 0;
        bit hs;
        for (int c = 0; c < max_cyc && idx < cnt; c++) begin
            s_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = sbuf[idx];
            hs      = s_valid && s_ready;
            @(negedge clk);
            if (hs) idx++;
        end
        s_valid = 1'b0;
        acc_n   = idx;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!res_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        rv_cyc = cyc;
        check(tag, res_valid, 1);
    endtask

    task automatic get_result(input logic [63:0] exp, input string tag);
        wait_valid({tag, "_valid"});
        check({tag, "_data"}, res_data, exp);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_vlow"}, res_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int a, base, rb, bad;
        for (int i = 0; i < 1024; i++) begin
            logic [25:0] r;
            r = 26'($urandom);
            sbuf[i] = DW'($signed(r));
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", controlArr, 1);
        check("rst_sready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rvalid", res_valid, 0);
        check("rst_rdata", res_data, 0);
        check("rst_we", we, 0);
        check("rst_addr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_renable", r_enable, 0);
        check("init_i", init_i, 0);
        check("init_acc", init_acc, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load and compute: 3^2+4^2+12^2 = 169
        sbuf[0] = 27'sd3; sbuf[1] = 27'sd4; sbuf[2] = 27'sd12;
        base = wr_cnt; rb = r_en_cnt; kern_delay = 3;
        do_start(3);
        feed(3, 1'b0, 20, a);
        check("t1_accepted", a, 3);
        get_result(64'd169, "t1");
        check("t1_nwr", wr_cnt - base, 3);
        for (int i = 0; i < 3; i++) check("t1_addr", wr_addr[base + i], i);
        check("t1_consec01", wr_cyc[base + 1] - wr_cyc[base], 1);
        check("t1_consec12", wr_cyc[base + 2] - wr_cyc[base + 1], 1);
        check("t1_nfire", r_en_cnt - rb, 1);
        check("t1_fire_after_last", r_en_cyc, wr_cyc[base + 2] + 1);
        check("t1_ctrl_at_fire", ctrl_at_fire, 0);
        check("t1_we_at_fire", we_at_fire, 0);

        // Full depth with random bubbles
        for (int i = 0; i < 1024; i++) begin
            logic [25:0] r;
            r = 26'($urandom);
            sbuf[i] = DW'($signed(r));
        end
        base = wr_cnt;
        do_start(1000);
        feed(1000, 1'b1, 5000, a);
        check("t2_accepted", a, 1000);
        get_result(ref_sum(1000), "t2");
        check("t2_nwr", wr_cnt - base, 1000);
        bad = 0;
        for (int i = 0; i < 1000; i++) if (wr_addr[base + i] != i) bad++;
        check("t2_addr_order", bad, 0);

        // Zero count fires the cycle after start
        base = wr_cnt; rb = r_en_cnt;
        do_start(0);
        get_result(64'd0, "t3a");
        check("t3a_nwr", wr_cnt - base, 0);
        check("t3a_nfire", r_en_cnt - rb, 1);
        check("t3a_fire_lat", r_en_cyc, start_cyc + 1);

        // Clamp 1023 -> 1000
        base = wr_cnt;
        do_start(1023);
        feed(1023, 1'b0, 1100, a);
        check("t3b_accepted", a, 1000);
        check("t3b_sready_low", s_ready, 0);
        get_result(ref_sum(1000), "t3b");
        check("t3b_nwr", wr_cnt - base, 1000);

        // Backpressure with stray start / w_enable in DONE: (-5)^2+7^2 = 74
        sbuf[0] = -27'sd5; sbuf[1] = 27'sd7;
        kern_delay = 2;
        do_start(2);
        feed(2, 1'b0, 20, a);
        wait_valid("t4_valid");
        rb = r_en_cnt;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin start = 1'b1; n = AW'(5); end
            if (k == 5) begin stray_wen = 1'b1; stray_res = 64'd999; end
            check("t4_hold_valid", res_valid, 1);
            check("t4_hold_data", res_data, 74);
            check("t4_hold_busy", busy, 1);
            @(negedge clk);
            start = 1'b0; stray_wen = 1'b0;
        end
        check("t4_no_fire", r_en_cnt - rb, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("t4_vlow", res_valid, 0);
        check("t4_idle", busy, 0);
        @(negedge clk);
        check("t4_not_queued", busy, 0);
        check("t4_ctrl", controlArr, 1);

        // Reset mid-LOAD
        for (int i = 0; i < 10; i++) sbuf[i] = DW'(i + 1);
        kern_delay = 3;
        do_start(10);
        feed(5, 1'b0, 20, a);
        check("t5_partial", a, 5);
        rb = r_en_cnt;
        rst_n = 1'b0;
        #1;
        check("t5_ctrl", controlArr, 1);
        check("t5_sready", s_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_we", we, 0);
        check("t5_addr", waddr, 0);
        check("t5_renable", r_enable, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_no_fire", r_en_cnt - rb, 0);
        sbuf[0] = 27'sd6; sbuf[1] = -27'sd8;
        do_start(2);
        feed(2, 1'b0, 20, a);
        get_result(64'd100, "t5_after");

        // Fast kernel: w_enable in the first WAIT cycle
        sbuf[0] = -27'sd11;
        kern_delay = 0;
        do_start(1);
        feed(1, 1'b0, 20, a);
        get_result(64'd121, "t6");
        check("t6_wen_cyc", wen_cyc, r_en_cyc + 1);
        check("t6_rv_cyc", rv_cyc, wen_cyc + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
